// File: rtl/cnn_batch_scheduler.sv
// cnn_batch_scheduler: streams image words into the enabled CNN cores, launches
// them together, collects predictions under a watchdog and drains the results
// as a tagged, back-pressurable stream.
module cnn_batch_scheduler #(
    parameter int N_CORES   = 4,
    parameter int IMG_WORDS = 64,
    parameter int DATA_W    = 32,
    parameter int PRED_W    = 32,
    parameter int TIMEOUT   = 4096,
    localparam int AW = $clog2(IMG_WORDS),
    localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    localparam int TW = $clog2(TIMEOUT)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      batch_start_i,
    input  logic [N_CORES-1:0]        core_en_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [DATA_W-1:0]         s_data_i,
    input  logic                      s_last_i,
    output logic [N_CORES-1:0]        core_wr_en_o,
    output logic [AW-1:0]             core_wr_addr_o,
    output logic [DATA_W-1:0]         core_wr_data_o,
    output logic [N_CORES-1:0]        core_start_o,
    input  logic [N_CORES-1:0]        core_done_i,
    input  logic [N_CORES*PRED_W-1:0] core_pred_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [PRED_W-1:0]         m_data_o,
    output logic [IW-1:0]             m_core_id_o,
    output logic                      m_timeout_o,
    output logic                      all_done_o,
    output logic                      busy_o,
    output logic                      err_len_o
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    localparam logic [AW-1:0] W_LAST = AW'(IMG_WORDS - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [1:0]         rst_sync_q;
    logic               rst_int_n;
    state_t             state_q, state_d;
    logic [N_CORES-1:0] mask_q, mask_d;
    logic [IW-1:0]      core_q, core_d;
    logic [AW-1:0]      w_q, w_d;
    logic               pad_q, pad_d;
    logic [N_CORES-1:0] wr_en_q, wr_en_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [N_CORES-1:0] start_q, start_d;
    logic               launched_q, launched_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [N_CORES-1:0] done_q, done_d;
    logic [PRED_W-1:0]  pred_q [N_CORES];
    logic [PRED_W-1:0]  pred_d [N_CORES];
    logic               all_done_q, all_done_d;
    logic               err_q, err_d;
    logic               hs;
    logic               nxt_found;
    logic [IW-1:0]      nxt_idx;
    logic [N_CORES-1:0] done_now;

    function automatic logic [IW-1:0] lowest(input logic [N_CORES-1:0] m);
        logic [IW-1:0] idx;
        idx = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            if (m[k]) idx = IW'(k);
        end
        return idx;
    endfunction

    // Reset deassertion synchroniser; assertion stays asynchronous.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync_q <= '0;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // Next-state, datapath and output decode for the batch FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        mask_d     = mask_q;
        core_d     = core_q;
        w_d        = w_q;
        pad_d      = pad_q;
        wr_en_d    = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        start_d    = '0;
        launched_d = launched_q;
        timer_d    = timer_q;
        done_d     = done_q;
        pred_d     = pred_q;
        all_done_d = 1'b0;
        err_d      = err_q;
        done_now   = done_q | (core_done_i & mask_q);

        s_ready_o  = (state_q == LOAD) && !pad_q;
        hs         = s_valid_i && s_ready_o;

        // Lowest enabled core strictly above the current one.
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            if (mask_q[k] && (k > int'(core_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = IW'(k);
            end
        end

        case (state_q)
            IDLE: begin
                if (batch_start_i) begin
                    err_d  = 1'b0;
                    done_d = '0;
                    if (core_en_i != '0) begin
                        mask_d     = core_en_i;
                        core_d     = lowest(core_en_i);
                        w_d        = '0;
                        pad_d      = 1'b0;
                        launched_d = 1'b0;
                        state_d    = LOAD;
                    end else begin
                        all_done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (hs || pad_q) begin
                    wr_en_d   = N_CORES'(1) << core_q;
                    wr_addr_d = w_q;
                    wr_data_d = pad_q ? '0 : s_data_i;
                    if (w_q == W_LAST) begin
                        if (hs && !s_last_i) err_d = 1'b1;
                        pad_d = 1'b0;
                        w_d   = '0;
                        if (nxt_found) core_d = nxt_idx;
                        else           state_d = RUN;
                    end else begin
                        w_d = w_q + AW'(1);
                        if (hs && s_last_i) begin
                            err_d = 1'b1;
                            pad_d = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                // First RUN cycle carries the final buffer write; launch follows it.
                if (!launched_q) begin
                    start_d    = mask_q;
                    launched_d = 1'b1;
                    timer_d    = '0;
                end else begin
                    for (int k = 0; k < N_CORES; k++) begin
                        if (core_done_i[k] && mask_q[k] && !done_q[k])
                            pred_d[k] = core_pred_i[k*PRED_W +: PRED_W];
                    end
                    done_d  = done_now;
                    timer_d = timer_q + TW'(1);
                    if ((done_now == mask_q) || (timer_q == T_LAST)) begin
                        core_d  = lowest(mask_q);
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_ready_i) begin
                    if (nxt_found) begin
                        core_d = nxt_idx;
                    end else begin
                        all_done_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the synchronised reset.
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            core_q     <= '0;
            w_q        <= '0;
            pad_q      <= 1'b0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            start_q    <= '0;
            launched_q <= 1'b0;
            timer_q    <= '0;
            done_q     <= '0;
            all_done_q <= 1'b0;
            err_q      <= 1'b0;
            // NOTE: the capture array is a handful of flops, so it is reset so
            // that a mid-batch abort cannot leak stale predictions.
            for (int k = 0; k < N_CORES; k++) pred_q[k] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            mask_q     <= mask_d;
            core_q     <= core_d;
            w_q        <= w_d;
            pad_q      <= pad_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            start_q    <= start_d;
            launched_q <= launched_d;
            timer_q    <= timer_d;
            done_q     <= done_d;
            all_done_q <= all_done_d;
            err_q      <= err_d;
            pred_q     <= pred_d;
        end
    end

    assign core_wr_en_o   = wr_en_q;
    assign core_wr_addr_o = wr_addr_q;
    assign core_wr_data_o = wr_data_q;
    assign core_start_o   = start_q;
    assign m_valid_o      = (state_q == DRAIN);
    assign m_core_id_o    = m_valid_o ? core_q : '0;
    assign m_data_o       = (m_valid_o && done_q[core_q]) ? pred_q[core_q] : '0;
    assign m_timeout_o    = m_valid_o && !done_q[core_q];
    assign all_done_o     = all_done_q;
    assign busy_o         = (state_q != IDLE);
    assign err_len_o      = err_q;

endmodule
